mac_cmd_sequencer: RTL
======================

Name: mac_cmd_sequencer

Overview:
- Upstream command source for the APB/AXI multiply subsystem.
- Queues multiply commands {raddr1, raddr2, waddr}, each of which means "read two operands, multiply, write back".
- Drives the subsystem's PWRITE/Raddr1/Raddr2/Waddr inputs one command at a time and waits for reading_completed, then write_completed.
- Returns operand1/operand2/result with a completion/error response over a valid/ready channel.

Parameters:
- ADDR_W, 32, width of all address fields.
- DEPTH, 4, command queue entries; power of two, at least 2.
- TIMEOUT, 256, cycles allowed per phase before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset; asynchronous assert, active-low (0 = reset)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept a command
- cmd_raddr1  in  ADDR_W  operand-1 address
- cmd_raddr2  in  ADDR_W  operand-2 address
- cmd_waddr  in  ADDR_W  product write address
- PWRITE  out  1  0 = read phase, 1 = write phase; to subsystem
- Raddr1  out  ADDR_W  to subsystem
- Raddr2  out  ADDR_W  to subsystem
- Waddr  out  ADDR_W  to subsystem
- reading_completed  in  1  subsystem read done
- write_completed  in  1  subsystem write done
- operand1  in  16  from subsystem
- operand2  in  16  from subsystem
- result  in  32  from subsystem
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_op1  out  16  captured operand1
- rsp_op2  out  16  captured operand2
- rsp_result  out  32  captured result
- rsp_err  out  1  1 = a phase timed out
- busy  out  1  FSM not in IDLE
- q_count  out  clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (PRESET=0, async): all outputs 0, FSM=IDLE, queue empty, timer 0. After reset, cmd_ready rises combinationally (count<DEPTH).
- Queue:
  - push on cmd_valid&&cmd_ready.
  - cmd_ready = (count!=DEPTH); there is no full-bypass, so a pop in the same cycle does not raise cmd_ready.
  - Simultaneous push and pop when not full: count unchanged, order preserved.
  - Read/write pointers wrap modulo DEPTH.
- FSM states:
  - IDLE:
    - if count!=0: pop head, register its addresses onto Raddr1/Raddr2/Waddr, PWRITE=0, timer=0, next state RD.
    - Addresses are held stable until the next launch.
  - RD:
    - reading_completed=1: capture operand1/operand2; PWRITE=1 next cycle; timer=0; go WR.
    - timer==TIMEOUT-1 with no completion (TIMEOUT!=0): rsp_err=1, result field 0, go RSP.
    - Completion in the same cycle as expiry: completion wins.
    - write_completed is ignored in RD.
  - WR:
    - write_completed=1: capture result; go RSP.
    - Same timeout rule as RD.
    - reading_completed is ignored in WR.
  - RSP:
    - rsp_valid=1; rsp_* held stable.
    - On rsp_ready: rsp_valid=0, PWRITE=0, go IDLE.
    - While rsp_valid=1, no new command launches; the queue keeps accepting pushes.
- Latency:
  - push accepted at edge 0 → q_count=1 after edge 0 → launch at edge 1, so Raddr*/busy are valid after edge 1.
  - reading_completed sampled at edge n → PWRITE=1 after edge n.
  - write_completed sampled at edge m → rsp_valid=1 after edge m.
  - Back-to-back: rsp_ready at edge k → IDLE after k → next launch at edge k+1.
- Timer: width clog2(TIMEOUT+1); saturates; used only in RD/WR.
- rsp_err clears when the next response is loaded.
- Reset mid-operation: everything returns to reset values; the in-flight command and all queued commands are discarded; PWRITE drops to 0 asynchronously.
- busy = (state!=IDLE).

Decomposition:
- Shared package mac_seq_pkg:
  - state enum {IDLE, RD, WR, RSP}
  - OPND_W=16, RES_W=32 constants
  - command struct {raddr1, raddr2, waddr}
- One sub-module: mac_cmd_fifo. Parameterised DEPTH/width, push/pop/count/full/empty, async active-low reset.
- The FSM and response registers stay in the top.

Test Plan:
- Single command (0x10, 0x14, 0x20):
  - reading_completed 3 cycles after launch with operand1=0x0003, operand2=0x0005.
  - write_completed 2 cycles later with result=0x0000000F.
  - Expect rsp_valid with op1=3, op2=5, result=15, err=0; PWRITE 0→1→0.
- Fill queue with 4 commands while the subsystem stalls:
  - Expect cmd_ready=0 with q_count=4; a 5th push is not accepted.
  - Complete the commands; expect responses in push order and cmd_ready reasserted after the first pop.
- TIMEOUT=8, never assert reading_completed:
  - Expect rsp_valid with rsp_err=1, result=0 exactly 8 cycles after launch.
  - The next command launches normally after rsp_ready.
- In RD, assert write_completed alone, then reading_completed:
  - Expect write_completed ignored; transition to WR only on reading_completed.
- Hold rsp_ready=0 for 10 cycles:
  - Expect rsp_* stable, no new launch, queue still accepting pushes.
- Drop PRESET in the WR phase with 2 commands queued:
  - Expect all outputs 0 immediately and q_count=0.
  - After release, a fresh command executes correctly.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the multiply-command sequencer.
package mac_seq_pkg;

    localparam int unsigned OPND_W     = 16;
    localparam int unsigned RES_W      = 32;
    localparam int unsigned CMD_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] raddr1;
        logic [CMD_ADDR_W-1:0] raddr2;
        logic [CMD_ADDR_W-1:0] waddr;
    } cmd_t;

endpackage

// File: rtl/mac_cmd_sequencer_if.sv
// Command, subsystem and response signals of the sequencer; slave is the sequencer's view.
interface mac_cmd_sequencer_if
    import mac_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) ();
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_raddr1;
    logic [ADDR_W-1:0] cmd_raddr2;
    logic [ADDR_W-1:0] cmd_waddr;

    logic              PWRITE;
    logic [ADDR_W-1:0] Raddr1;
    logic [ADDR_W-1:0] Raddr2;
    logic [ADDR_W-1:0] Waddr;
    logic              reading_completed;
    logic              write_completed;
    logic [OPND_W-1:0] operand1;
    logic [OPND_W-1:0] operand2;
    logic [RES_W-1:0]  result;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [OPND_W-1:0] rsp_op1;
    logic [OPND_W-1:0] rsp_op2;
    logic [RES_W-1:0]  rsp_result;
    logic              rsp_err;

    logic              busy;
    logic [CNT_W-1:0]  q_count;

    modport slave (
        input  cmd_valid, cmd_raddr1, cmd_raddr2, cmd_waddr,
        input  reading_completed, write_completed, operand1, operand2, result,
        input  rsp_ready,
        output cmd_ready, PWRITE, Raddr1, Raddr2, Waddr,
        output rsp_valid, rsp_op1, rsp_op2, rsp_result, rsp_err, busy, q_count
    );

    modport master (
        output cmd_valid, cmd_raddr1, cmd_raddr2, cmd_waddr,
        output reading_completed, write_completed, operand1, operand2, result,
        output rsp_ready,
        input  cmd_ready, PWRITE, Raddr1, Raddr2, Waddr,
        input  rsp_valid, rsp_op1, rsp_op2, rsp_result, rsp_err, busy, q_count
    );

endinterface

// File: rtl/mac_cmd_fifo.sv
// Power-of-two command queue; pointers wrap naturally, count tracks occupancy.
module mac_cmd_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 96,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c,
    output logic [CNT_W-1:0] count,
    output logic             full_c,
    output logic             empty_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign rdata_c = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/mac_cmd_sequencer.sv
// Issues queued multiply commands to the subsystem one at a time and returns
// captured operands/result (or a timeout error) over a valid/ready response.
module mac_cmd_sequencer
    import mac_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input logic                PCLK,
    input logic                PRESET,
    mac_cmd_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] raddr1_q, raddr1_d;
    logic [ADDR_W-1:0] raddr2_q, raddr2_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [OPND_W-1:0] op1_q, op1_d;
    logic [OPND_W-1:0] op2_q, op2_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;

    cmd_t              push_data_c;
    cmd_t              head_c;
    logic              pop_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [CNT_W-1:0]  fifo_count;
    logic              expired_c;

    assign push_data_c.raddr1 = CMD_ADDR_W'(bus.cmd_raddr1);
    assign push_data_c.raddr2 = CMD_ADDR_W'(bus.cmd_raddr2);
    assign push_data_c.waddr  = CMD_ADDR_W'(bus.cmd_waddr);

    mac_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk     (PCLK),
        .rst_n   (PRESET),
        .push    (bus.cmd_valid),
        .pop     (pop_c),
        .wdata   (push_data_c),
        .rdata_c (head_c),
        .count   (fifo_count),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    assign expired_c = (TIMEOUT != 0) && (timer_q == TMR_LAST);

    // Next-state and next-register values; completion takes priority over expiry.
    always_comb begin
        state_d     = state_q;
        timer_d     = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
        pwrite_d    = pwrite_q;
        raddr1_d    = raddr1_q;
        raddr2_d    = raddr2_q;
        waddr_d     = waddr_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        res_d       = res_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        pop_c       = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!fifo_empty_c) begin
                    pop_c    = 1'b1;
                    raddr1_d = ADDR_W'(head_c.raddr1);
                    raddr2_d = ADDR_W'(head_c.raddr2);
                    waddr_d  = ADDR_W'(head_c.waddr);
                    pwrite_d = 1'b0;
                    state_d  = RD;
                end
            end
            RD: begin
                if (bus.reading_completed) begin
                    op1_d    = bus.operand1;
                    op2_d    = bus.operand2;
                    pwrite_d = 1'b1;
                    timer_d  = '0;
                    state_d  = WR;
                end else if (expired_c) begin
                    op1_d       = '0;
                    op2_d       = '0;
                    res_d       = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            WR: begin
                if (bus.write_completed) begin
                    res_d       = bus.result;
                    err_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else if (expired_c) begin
                    res_d       = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                timer_d = '0;
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    pwrite_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            pwrite_q    <= 1'b0;
            raddr1_q    <= '0;
            raddr2_q    <= '0;
            waddr_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pwrite_q    <= pwrite_d;
            raddr1_q    <= raddr1_d;
            raddr2_q    <= raddr2_d;
            waddr_q     <= waddr_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            res_q       <= res_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.cmd_ready  = !fifo_full_c;
    assign bus.PWRITE     = pwrite_q;
    assign bus.Raddr1     = raddr1_q;
    assign bus.Raddr2     = raddr2_q;
    assign bus.Waddr      = waddr_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_op1    = op1_q;
    assign bus.rsp_op2    = op2_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.q_count    = fifo_count;

endmodule
